// File: rtl/fw_dest_pipe.sv
// Destination-register pipeline for the forwarding unit, covering EX, MEM and WB.
// It also detects the hazards that forwarding cannot resolve: load-use and HI/LO reads while mult/div is busy.
module fw_dest_pipe #(
   parameter int unsigned MD_CYCLES = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pause,
   input  logic       flush,
   input  logic [4:0] id_wr_rn,
   input  logic       id_we,
   input  logic       id_is_load,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rs,
   input  logic       id_uses_rt,
   input  logic       id_md_start,
   input  logic       id_hilo_rd,
   output logic       alu_we,
   output logic [4:0] fw_alu_rn,
   output logic       mem_We,
   output logic [4:0] fw_mem_rn,
   output logic       wb_we,
   output logic [4:0] wb_rn,
   output logic       load_stall,
   output logic       md_busy,
   output logic       stall_o
);

   localparam int unsigned RN_W  = 5;
   localparam int unsigned CNT_W = 6;

   typedef struct packed {
      logic [RN_W-1:0] rn;
      logic            we;
      logic            is_load;
   } stage_t;

   localparam stage_t BUBBLE = '0;

   stage_t           ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
   logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
   logic             rs_hit, rt_hit, md_stall;

   // Hazard detection from the ID operands against the load currently in EX
   always_comb begin
      rs_hit     = id_uses_rs & (id_rs == ex_q.rn);
      rt_hit     = id_uses_rt & (id_rt == ex_q.rn);
      load_stall = ex_q.is_load & ex_q.we & (rs_hit | rt_hit);
      md_busy    = (md_cnt_q != '0);
      md_stall   = md_busy & (id_hilo_rd | id_md_start);
      stall_o    = load_stall | md_stall;
   end

   // A load's result is not yet available in EX, so it cannot be forwarded from there
   assign alu_we    = ex_q.we & ~ex_q.is_load;
   assign fw_alu_rn = ex_q.rn;
   assign mem_We    = mem_q.we;
   assign fw_mem_rn = mem_q.rn;
   assign wb_we     = wb_q.we;
   assign wb_rn     = wb_q.rn;

   // Stage advance and mult/div countdown
   always_comb begin
      ex_d     = ex_q;
      mem_d    = mem_q;
      wb_d     = wb_q;
      md_cnt_d = md_cnt_q;

      if (!pause) begin
         wb_d  = mem_q;
         mem_d = ex_q;
         if (flush | stall_o) begin
            ex_d = BUBBLE;
         end else begin
            ex_d.rn      = id_wr_rn;
            ex_d.we      = id_we & (id_wr_rn != '0);
            ex_d.is_load = id_is_load;
         end
      end

      // The counter keeps running through pause so that a freeze never stretches the busy window
      if (id_md_start & ~md_busy & ~stall_o & ~flush & ~pause) begin
         md_cnt_d = CNT_W'(MD_CYCLES);
      end else if (md_busy) begin
         md_cnt_d = md_cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_q     <= BUBBLE;
         mem_q    <= BUBBLE;
         wb_q     <= BUBBLE;
         md_cnt_q <= '0;
      end else begin
         ex_q     <= ex_d;
         mem_q    <= mem_d;
         wb_q     <= wb_d;
         md_cnt_q <= md_cnt_d;
      end
   end

endmodule

// File: tb/tb_fw_dest_pipe.sv
// Bench for fw_dest_pipe: directed scenarios and random traffic, checked against a stage-list reference model.
module tb_fw_dest_pipe;

   localparam int unsigned MD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       pause = 1'b0, flush = 1'b0;
   logic [4:0] id_wr_rn = '0, id_rs = '0, id_rt = '0;
   logic       id_we = 1'b0, id_is_load = 1'b0, id_uses_rs = 1'b0, id_uses_rt = 1'b0;
   logic       id_md_start = 1'b0, id_hilo_rd = 1'b0;
   logic       alu_we, mem_We, wb_we, load_stall, md_busy, stall_o;
   logic [4:0] fw_alu_rn, fw_mem_rn, wb_rn;

   fw_dest_pipe #(.MD_CYCLES(MD)) dut (
      .clk(clk), .rst(rst), .pause(pause), .flush(flush),
      .id_wr_rn(id_wr_rn), .id_we(id_we), .id_is_load(id_is_load),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_md_start(id_md_start), .id_hilo_rd(id_hilo_rd),
      .alu_we(alu_we), .fw_alu_rn(fw_alu_rn), .mem_We(mem_We), .fw_mem_rn(fw_mem_rn),
      .wb_we(wb_we), .wb_rn(wb_rn), .load_stall(load_stall), .md_busy(md_busy),
      .stall_o(stall_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: index 0 = EX, 1 = MEM, 2 = WB; md_left counts remaining busy cycles
   int m_rn [3];
   bit m_we [3];
   bit m_ld [3];
   int md_left;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit exp_load_stall();
      bit hit;
      hit = (id_uses_rs && int'(id_rs) == m_rn[0]) || (id_uses_rt && int'(id_rt) == m_rn[0]);
      return m_ld[0] && m_we[0] && hit;
   endfunction

   function automatic bit exp_stall();
      return exp_load_stall() || (md_left > 0 && (id_hilo_rd || id_md_start));
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 3; i++) begin
         m_rn[i] = 0; m_we[i] = 0; m_ld[i] = 0;
      end
      md_left = 0;
   endtask

   task automatic check_outputs();
      chk("alu_we",     32'(alu_we),     32'(m_we[0] && !m_ld[0]));
      chk("fw_alu_rn",  32'(fw_alu_rn),  32'(m_rn[0]));
      chk("mem_We",     32'(mem_We),     32'(m_we[1]));
      chk("fw_mem_rn",  32'(fw_mem_rn),  32'(m_rn[1]));
      chk("wb_we",      32'(wb_we),      32'(m_we[2]));
      chk("wb_rn",      32'(wb_rn),      32'(m_rn[2]));
      chk("load_stall", 32'(load_stall), 32'(exp_load_stall()));
      chk("md_busy",    32'(md_busy),    32'(md_left > 0));
      chk("stall_o",    32'(stall_o),    32'(exp_stall()));
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_alu_we"},  32'(alu_we),  32'(0));
      chk({tag, "_alu_rn"},  32'(fw_alu_rn), 32'(0));
      chk({tag, "_mem_we"},  32'(mem_We),  32'(0));
      chk({tag, "_mem_rn"},  32'(fw_mem_rn), 32'(0));
      chk({tag, "_wb_we"},   32'(wb_we),   32'(0));
      chk({tag, "_wb_rn"},   32'(wb_rn),   32'(0));
      chk({tag, "_ldst"},    32'(load_stall), 32'(0));
      chk({tag, "_busy"},    32'(md_busy), 32'(0));
      chk({tag, "_stall"},   32'(stall_o), 32'(0));
   endtask

   // Called at a falling edge with inputs already applied; returns at the next falling edge
   task automatic cycle();
      int  n_rn;
      bit  n_we, n_ld, st, start;
      #1;
      check_outputs();
      st    = exp_stall();
      start = id_md_start && md_left == 0 && !st && !flush && !pause;
      n_rn  = int'(id_wr_rn);
      n_we  = id_we && id_wr_rn != 0;
      n_ld  = id_is_load;
      @(posedge clk);
      if (!pause) begin
         for (int i = 2; i > 0; i--) begin
            m_rn[i] = m_rn[i-1]; m_we[i] = m_we[i-1]; m_ld[i] = m_ld[i-1];
         end
         if (flush || st) begin
            m_rn[0] = 0; m_we[0] = 0; m_ld[0] = 0;
         end else begin
            m_rn[0] = n_rn; m_we[0] = n_we; m_ld[0] = n_ld;
         end
      end
      if (start)            md_left = MD;
      else if (md_left > 0) md_left--;
      @(negedge clk);
   endtask

   task automatic set_idle();
      pause = 0; flush = 0; id_wr_rn = 0; id_we = 0; id_is_load = 0;
      id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
      id_md_start = 0; id_hilo_rd = 0;
   endtask

   task automatic set_instr(input int rn, input bit we, input bit ld, input int rs, input bit urs);
      set_idle();
      id_wr_rn = 5'(rn); id_we = we; id_is_load = ld;
      id_rs = 5'(rs); id_uses_rs = urs;
   endtask

   task automatic drain(input int n);
      set_idle();
      for (int i = 0; i < n; i++) cycle();
   endtask

   int busy_cnt, stall_cnt, ls_cnt;

   initial begin
      model_clear();
      #2;
      check_all_zero("por");
      @(negedge clk);
      rst = 1;

      // Mid-stream reset with r5/r6/r7 in flight
      set_instr(7, 1, 0, 0, 0); cycle();
      set_instr(6, 1, 0, 0, 0); cycle();
      set_instr(5, 1, 0, 0, 0); cycle();
      chk("pre_rst_wb_rn", 32'(wb_rn), 32'(7));
      set_idle();
      #2 rst = 0;
      #1 check_all_zero("async_rst");
      model_clear();
      @(negedge clk);
      rst = 1;

      // First instruction after release walks EX -> MEM -> WB
      set_instr(3, 1, 0, 0, 0); cycle();
      set_idle();
      #1 chk("lat_ex_rn", 32'(fw_alu_rn), 32'(3));
      cycle();
      chk("lat_mem_we", 32'(mem_We), 32'(1));
      cycle();
      chk("lat_wb_rn", 32'(wb_rn), 32'(3));
      drain(2);

      // Load-use: exactly one stall cycle, consumer then forwards from MEM
      set_instr(8, 1, 1, 0, 0); cycle();
      set_instr(9, 1, 0, 8, 1);
      ls_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         #1 if (load_stall) ls_cnt++;
         if (i == 1) begin
            chk("lu_bubble_alu_we", 32'(alu_we), 32'(0));
            chk("lu_mem_rn", 32'(fw_mem_rn), 32'(8));
         end
         cycle();
         if (i == 1) set_idle();
      end
      chk("lu_stall_cycles", 32'(ls_cnt), 32'(1));
      drain(3);

      // Same pair without reading rs: no stall
      set_instr(8, 1, 1, 0, 0); cycle();
      set_instr(9, 1, 0, 8, 0);
      #1 chk("lu_unused_rs", 32'(load_stall), 32'(0));
      cycle();
      drain(3);

      // Writes to r0 never enable, and a load to r0 causes no stall
      set_instr(0, 1, 0, 0, 0); cycle();
      set_instr(0, 1, 1, 0, 0); cycle();
      set_instr(4, 1, 0, 0, 1); cycle();
      drain(3);

      // Pause freezes r9 in EX and r10 in MEM
      set_instr(10, 1, 0, 0, 0); cycle();
      set_instr(9, 1, 0, 0, 0); cycle();
      set_instr(11, 1, 0, 0, 0);
      pause = 1;
      for (int i = 0; i < 3; i++) cycle();
      chk("pause_ex_rn", 32'(fw_alu_rn), 32'(9));
      chk("pause_mem_rn", 32'(fw_mem_rn), 32'(10));
      pause = 0;
      cycle();
      drain(3);

      // Mult/div: busy exactly MD cycles even with a pause inside the window
      set_idle(); id_md_start = 1; cycle();
      set_instr(12, 1, 0, 0, 0); id_hilo_rd = 1;
      busy_cnt = 0; stall_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         pause = (i == 1 || i == 2);
         #1;
         if (md_busy) busy_cnt++;
         if (stall_o) stall_cnt++;
         cycle();
      end
      chk("md_busy_cycles", 32'(busy_cnt), 32'(MD));
      chk("md_stall_cycles", 32'(stall_cnt), 32'(MD));
      drain(3);

      // Flush coinciding with load stall, then flush under pause
      set_instr(8, 1, 1, 0, 0); cycle();
      set_instr(13, 1, 0, 8, 1); flush = 1; cycle();
      set_instr(14, 1, 0, 0, 0); flush = 1; pause = 1; cycle();
      pause = 0; flush = 0; cycle();
      drain(3);

      // Random traffic over a narrow register range to provoke hazards
      for (int i = 0; i < 400; i++) begin
         set_idle();
         id_wr_rn    = 5'($urandom_range(0, 5));
         id_we       = 1'($urandom_range(0, 3) != 0);
         id_is_load  = 1'($urandom_range(0, 2) == 0);
         id_rs       = 5'($urandom_range(0, 5));
         id_rt       = 5'($urandom_range(0, 5));
         id_uses_rs  = 1'($urandom);
         id_uses_rt  = 1'($urandom);
         id_md_start = 1'($urandom_range(0, 9) == 0);
         id_hilo_rd  = 1'($urandom_range(0, 6) == 0);
         pause       = 1'($urandom_range(0, 6) == 0);
         flush       = 1'($urandom_range(0, 9) == 0);
         cycle();
         if (i == 200) begin
            #2 rst = 0;
            #1 check_all_zero("rand_rst");
            model_clear();
            @(negedge clk);
            rst = 1;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fw_dest_pipe.md
# fw_dest_pipe

Producer side of the forwarding protocol: tracks destination register number and write-enable of each instruction from ID through EX, MEM and WB. It drives the `alu_we`/`fw_alu_rn` and `mem_We`/`fw_mem_rn` inputs consumed by the forwarding unit, plus the register-file write port. It also detects the hazards that forwarding cannot cover (load-use, HI/LO read during multiply/divide) and requests an ID stall while injecting a bubble into EX.

## Interface
- `MD_CYCLES`, 32: multiply/divide busy duration in cycles, 1..63.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `pause` in 1: global freeze (memory wait); holds all stage registers.
- `flush` in 1: squash the instruction leaving ID; a bubble enters EX.
- `id_wr_rn` in 5: destination register of the instruction in ID.
- `id_we` in 1: the ID instruction writes the register file.
- `id_is_load` in 1: the ID instruction is a load.
- `id_rs`, `id_rt` in 5 each: source registers of the ID instruction.
- `id_uses_rs`, `id_uses_rt` in 1 each: the source is actually read.
- `id_md_start` in 1: the ID instruction starts mult/div.
- `id_hilo_rd` in 1: the ID instruction reads HI/LO (mfhi/mflo).
- `alu_we` out 1, `fw_alu_rn` out 5: EX-stage forwarding source.
- `mem_We` out 1, `fw_mem_rn` out 5: MEM-stage forwarding source.
- `wb_we` out 1, `wb_rn` out 5: register-file write port control.
- `load_stall` out 1: load-use hazard, combinational.
- `md_busy` out 1: the mult/div counter is nonzero.
- `stall_o` out 1: `load_stall | md_stall`; freezes PC and IF/ID.

## Operation
- Stage state per EX/MEM/WB: `rn[4:0]`, `we`, `is_load`. A bubble is `rn=0`, `we=0`, `is_load=0`.
- Effective write enable at capture: `id_we & (id_wr_rn != 0)`. Register 0 never appears with `we=1`.
- Outputs:
  - `fw_alu_rn = ex.rn`, `alu_we = ex.we & ~ex.is_load`. A load's data does not exist in EX.
  - `fw_mem_rn = mem.rn`, `mem_We = mem.we`.
  - `wb_rn = wb.rn`, `wb_we = wb.we`.
- `load_stall = ex.is_load & ex.we & ((id_uses_rs & id_rs==ex.rn) | (id_uses_rt & id_rt==ex.rn))`.
- Mult/div counter `md_cnt[5:0]`:
  - `id_md_start` with `md_cnt==0` and no stall/flush/pause loads `MD_CYCLES`.
  - Otherwise it decrements when nonzero, every cycle, including during `pause`.
  - `id_md_start` while busy is held in ID by `md_stall`; it never reloads.
  - `md_stall = (md_cnt!=0) & (id_hilo_rd | id_md_start)`.
- Per-edge update, in priority order:
  1. `pause` = 1: EX, MEM and WB all hold.
  2. Otherwise: WB←MEM and MEM←EX. EX←bubble if `flush | stall_o`, else EX←ID fields.
- `flush` and a stall in the same cycle produce one bubble. `stall_o` is still reported; ID hold is the fetch unit's concern.

## Timing
- Reset (`rst`=0, asynchronous): all stage registers become bubbles and `md_cnt`=0. Every output is 0: `alu_we`, `mem_We`, `wb_we`, `load_stall`, `md_busy`, `stall_o`, and all rn outputs.
- Reset mid-operation clears in-flight writes immediately; there is no partial writeback.
- Latency: an instruction captured at edge n drives the EX outputs during cycle n..n+1, MEM one cycle later and WB two cycles later (without pause).
- Load-use:
  - Cycle n: `load_stall`=1.
  - Edge n: bubble into EX, load into MEM.
  - Cycle n+1: `load_stall`=0, `mem_We` with `fw_mem_rn`=load rn. The consumer proceeds and forwards from MEM.
- `load_stall` and `stall_o` are combinational from ID inputs and registered stage state. There is no registered stall output.
- During `pause`, outputs stay constant. Stall outputs may change only through ID inputs and `md_cnt`.
- `md_busy` rises the cycle after the start edge and stays high exactly `MD_CYCLES` cycles.

## Test plan
- Reset with `rst`=0 mid-stream, with EX/MEM/WB holding writes to r5, r6, r7 → all outputs 0 asynchronously. After release, the first instruction (`id_we`=1, rn=3) shows `alu_we`=1, `fw_alu_rn`=3 after one edge, then `mem_We` after two, then `wb_we` after three.
- Load r8 followed by add reading `id_rs`=8 → `load_stall`=1 for exactly one cycle. The next cycle shows `alu_we`=0 (bubble) and `mem_We`=1, `fw_mem_rn`=8. The same pair with `id_uses_rs`=0 → no stall.
- `id_wr_rn`=0 with `id_we`=1 → `alu_we`, `mem_We` and `wb_we` stay 0 through all stages. A load to r0 followed by a consumer of r0 → no stall.
- `pause`=1 for 3 cycles with r9 in EX and r10 in MEM → outputs frozen at r9/r10. After release they advance one stage per cycle.
- `MD_CYCLES`=4: md_start, then `id_hilo_rd` on the next instruction → `md_busy` is 1 for 4 cycles and `stall_o`=1 throughout. The stall releases on the cycle `md_cnt` reaches 0. `pause` asserted during busy does not extend it.
- `flush` and `load_stall` together → exactly one bubble enters EX. `flush` with `pause` → hold, and the flush has no effect that cycle.
